// File: rtl/rr_mux_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter_pkg
// Purpose  : Shared constants, state encoding and helpers for the
//            round-robin packet arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rr_mux_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One-hot decode of a requester index
  function automatic logic [NUM_REQ-1:0] onehot_from_idx(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter_if
// Purpose  : Producer-side and consumer-side channel bundle for the arbiter.
//            The slave modport is the arbiter's view.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_mux_arbiter_if #(
  parameter int DATA_W = 4
);
  import rr_mux_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [DATA_W-1:0]  data_a;
  logic [DATA_W-1:0]  data_b;
  logic [DATA_W-1:0]  data_c;
  logic [DATA_W-1:0]  data_d;
  logic [NUM_REQ-1:0] last;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] req_ready;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_last;
  logic               out_ready;
  logic [SEL_W-1:0]   sel;
  logic               overrun;

  modport slave (
    input  req, data_a, data_b, data_c, data_d, last, out_ready,
    output gnt, req_ready, out_valid, out_data, out_last, sel, overrun
  );

  modport master (
    output req, data_a, data_b, data_c, data_d, last, out_ready,
    input  gnt, req_ready, out_valid, out_data, out_last, sel, overrun
  );

endinterface
`default_nettype wire

// File: rtl/rr_mux_arbiter_pick4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Purpose  : Combinational round-robin search: first set request bit found
//            starting at ptr and wrapping modulo 4.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
  import rr_mux_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest hit wins
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter
// Purpose  : Four-way round-robin packet arbiter onto one valid/ready
//            channel. A grant is held until a last beat (or an overrun of
//            MAX_BEATS) is accepted; one IDLE cycle separates packets.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_mux_arbiter_if.slave bus
);

  localparam int             CNT_W     = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS - 1);

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   sel_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [CNT_W-1:0]   beat_cnt;
  logic               overrun_q;

  logic               found;
  logic [SEL_W-1:0]   pick_idx;
  logic               busy;
  logic [DATA_W-1:0]  mux_data;
  logic               xfer;

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick_idx)
  );

  assign busy = (state == BUSY);

  // 4:1 data select from the granted port
  always_comb begin
    mux_data = '0;
    case (sel_q)
      2'd0:    mux_data = bus.data_a;
      2'd1:    mux_data = bus.data_b;
      2'd2:    mux_data = bus.data_c;
      default: mux_data = bus.data_d;
    endcase
  end

  // Outputs are gated by BUSY so IDLE and reset present an empty channel
  assign bus.out_valid = busy & bus.req[sel_q];
  assign bus.out_last  = busy & bus.last[sel_q];
  assign bus.out_data  = busy ? mux_data : '0;
  assign xfer          = bus.out_valid & bus.out_ready;

  assign bus.gnt       = gnt_q;
  assign bus.req_ready = gnt_q & {NUM_REQ{bus.out_ready}};
  assign bus.sel       = sel_q;
  assign bus.overrun   = overrun_q;

  // Grant FSM: pick in IDLE, hold through the packet, release on last/overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      beat_cnt  <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel_q <= pick_idx;
            gnt_q <= onehot_from_idx(pick_idx);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            if (bus.out_last || beat_cnt == CNT_LIMIT) begin
              if (!bus.out_last) begin
                overrun_q <= 1'b1;
              end
              state    <= IDLE;
              gnt_q    <= '0;
              ptr      <= sel_q + SEL_W'(1);
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Purpose  : Directed self-checking bench for rr_mux_arbiter (MAX_BEATS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  rr_mux_arbiter_if #(.DATA_W(4)) bus ();

  rr_mux_arbiter #(
    .DATA_W    (4),
    .MAX_BEATS (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_data [4];
  int         seq [6];

  initial begin
    checks   = 0;
    failures = 0;
    exp_data = '{4'h1, 4'h2, 4'hA, 4'h4};
    seq      = '{3, 0, 1, 2, 3, 0};

    rst_n         = 1'b0;
    bus.req       = 4'b0000;
    bus.last      = 4'b0000;
    bus.out_ready = 1'b0;
    bus.data_a    = 4'h1;
    bus.data_b    = 4'h2;
    bus.data_c    = 4'hA;
    bus.data_d    = 4'h4;
    tick();
    tick();

    // Reset state
    check("rst_gnt",       bus.gnt, 4'b0000);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data",  bus.out_data, 4'h0);
    check("rst_out_last",  bus.out_last, 1'b0);
    check("rst_req_ready", bus.req_ready, 4'b0000);
    check("rst_sel",       bus.sel, 2'd0);
    check("rst_overrun",   bus.overrun, 1'b0);

    rst_n = 1'b1;

    // Single 1-beat packet from requester 2
    bus.req       = 4'b0100;
    bus.last      = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    check("t1_gnt_idle", bus.gnt, 4'b0000);
    tick();
    check("t1_gnt",       bus.gnt, 4'b0100);
    check("t1_sel",       bus.sel, 2'd2);
    check("t1_out_data",  bus.out_data, 4'hA);
    check("t1_out_last",  bus.out_last, 1'b1);
    check("t1_req_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req  = 4'b0000;
    bus.last = 4'b0000;
    #1;
    check("t1_gnt_after",   bus.gnt, 4'b0000);
    check("t1_valid_after", bus.out_valid, 1'b0);

    // All four requesting 1-beat packets; ptr=3 so 3 goes first
    bus.req  = 4'b1111;
    bus.last = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_sel",       bus.sel, seq[i]);
      check("t2_gnt",       bus.gnt, 4'b0001 << seq[i]);
      check("t2_out_data",  bus.out_data, exp_data[seq[i]]);
      check("t2_req_ready", bus.req_ready, 4'b0001 << seq[i]);
      tick();
      check("t2_idle_gnt",   bus.gnt, 4'b0000);
      check("t2_idle_valid", bus.out_valid, 1'b0);
    end
    bus.req  = 4'b0000;
    bus.last = 4'b0000;

    // Requester 1, 3-beat packet with ready toggling; requester 0 joins midway
    bus.req       = 4'b0010;
    bus.data_b    = 4'h5;
    bus.out_ready = 1'b1;
    tick();
    check("t3_b1_gnt",  bus.gnt, 4'b0010);
    check("t3_b1_data", bus.out_data, 4'h5);
    check("t3_b1_rdy",  bus.req_ready, 4'b0010);
    tick();
    bus.data_b    = 4'h6;
    bus.out_ready = 1'b0;
    bus.req       = 4'b0011;
    #1;
    check("t3_stall_gnt",  bus.gnt, 4'b0010);
    check("t3_stall_rdy",  bus.req_ready, 4'b0000);
    check("t3_stall_data", bus.out_data, 4'h6);
    tick();
    bus.out_ready = 1'b1;
    #1;
    check("t3_b2_rdy",  bus.req_ready, 4'b0010);
    check("t3_b2_data", bus.out_data, 4'h6);
    tick();
    bus.data_b    = 4'h7;
    bus.last      = 4'b0010;
    bus.out_ready = 1'b0;
    #1;
    check("t3_b3_gnt",  bus.gnt, 4'b0010);
    check("t3_b3_last", bus.out_last, 1'b1);
    tick();
    bus.out_ready = 1'b1;
    #1;
    check("t3_b3_rdy",  bus.req_ready, 4'b0010);
    check("t3_b3_data", bus.out_data, 4'h7);
    tick();
    bus.req  = 4'b0001;
    bus.last = 4'b0001;
    #1;
    check("t3_idle_gnt", bus.gnt, 4'b0000);
    tick();
    check("t3_next_gnt", bus.gnt, 4'b0001);
    check("t3_next_sel", bus.sel, 2'd0);
    tick();
    bus.req  = 4'b0000;
    bus.last = 4'b0000;

    // Requester 2 bubbles for two cycles mid-packet
    bus.req  = 4'b0100;
    bus.data_c = 4'hA;
    tick();
    check("t4_gnt", bus.gnt, 4'b0100);
    tick();
    bus.req = 4'b0011;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("t4_bub_valid", bus.out_valid, 1'b0);
      check("t4_bub_gnt",   bus.gnt, 4'b0100);
      check("t4_bub_rdy",   bus.req_ready & 4'b1011, 4'b0000);
      tick();
    end
    bus.req  = 4'b0111;
    bus.last = 4'b0100;
    #1;
    check("t4_resume_valid", bus.out_valid, 1'b1);
    check("t4_resume_last",  bus.out_last, 1'b1);
    check("t4_resume_rdy",   bus.req_ready, 4'b0100);
    tick();
    bus.req  = 4'b0000;
    bus.last = 4'b0000;
    #1;
    check("t4_release_gnt", bus.gnt, 4'b0000);

    // Requester 3 overruns MAX_BEATS=4
    bus.req = 4'b1000;
    tick();
    check("t5_gnt",     bus.gnt, 4'b1000);
    check("t5_ovr_pre", bus.overrun, 1'b0);
    tick();
    tick();
    tick();
    check("t5_ovr_b3",  bus.overrun, 1'b0);
    check("t5_gnt_b3",  bus.gnt, 4'b1000);
    tick();
    check("t5_ovr",       bus.overrun, 1'b1);
    check("t5_rel_gnt",   bus.gnt, 4'b0000);
    check("t5_rel_valid", bus.out_valid, 1'b0);
    bus.req = 4'b1001;
    tick();
    check("t5_next_gnt", bus.gnt, 4'b0001);
    check("t5_next_sel", bus.sel, 2'd0);
    check("t5_ovr_held", bus.overrun, 1'b1);

    // Asynchronous reset mid-packet
    bus.req = 4'b0001;
    #1;
    check("t6_mid_valid", bus.out_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_gnt",     bus.gnt, 4'b0000);
    check("t6_rst_valid",   bus.out_valid, 1'b0);
    check("t6_rst_rdy",     bus.req_ready, 4'b0000);
    check("t6_rst_overrun", bus.overrun, 1'b0);
    check("t6_rst_sel",     bus.sel, 2'd0);
    #3;
    rst_n    = 1'b1;
    bus.req  = 4'b0011;
    bus.last = 4'b0011;
    #1;
    check("t6_idle_gnt", bus.gnt, 4'b0000);
    tick();
    check("t6_first_gnt", bus.gnt, 4'b0001);
    tick();
    check("t6_gap_gnt", bus.gnt, 4'b0000);
    tick();
    check("t6_second_gnt", bus.gnt, 4'b0010);
    bus.req  = 4'b0000;
    bus.last = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
